// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: next-PC mode encodings and trap-level state type shared by the PC sequencer
package pc_seq_pkg;
  localparam int NPC_SEL_W = 3;
  localparam logic [NPC_SEL_W-1:0] NPC_SEQ    = 3'd0;
  localparam logic [NPC_SEL_W-1:0] NPC_BRANCH = 3'd1;
  localparam logic [NPC_SEL_W-1:0] NPC_JUMP   = 3'd2;
  localparam logic [NPC_SEL_W-1:0] NPC_JR     = 3'd3;
  localparam logic [NPC_SEL_W-1:0] NPC_ERET   = 3'd4;
  typedef enum logic {NORMAL, TRAPPED} trap_state_t;
endpackage

// File: rtl/jump_target_gen.sv
// jump_target_gen: branch/jump target arithmetic and jump-register alignment check
module jump_target_gen #(
  parameter int XLEN   = 32,
  parameter int JIDX_W = 26,
  parameter int IMM_W  = 16
) (
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [XLEN-1:0]   rs_val,
  output logic [XLEN-1:0]   branch_target,
  output logic [XLEN-1:0]   jump_target,
  output logic              misaligned
);
  logic [XLEN-1:0] offset;
  assign offset        = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm} << 2;
  assign branch_target = pc_plus4 + offset;
  assign jump_target   = {pc_plus4[XLEN-1:JIDX_W+2], jidx, 2'b00};
  assign misaligned    = |rs_val[1:0];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC selection and single-level trap/EPC handling
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              JIDX_W       = 26,
  parameter int              IMM_W        = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NPC_SEL_W-1:0] npc_sel,
  input  logic                 branch_taken,
  input  logic [IMM_W-1:0]     imm,
  input  logic [JIDX_W-1:0]    jidx,
  input  logic [XLEN-1:0]      rs_val,
  input  logic                 trap_req,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_plus4,
  output logic [XLEN-1:0]      next_pc,
  output logic [XLEN-1:0]      epc,
  output logic                 in_trap,
  output logic                 addr_err
);
  trap_state_t     state;
  logic [XLEN-1:0] branch_target, jump_target, cand;
  logic            misaligned, trap, eret;
  jump_target_gen #(.XLEN(XLEN), .JIDX_W(JIDX_W), .IMM_W(IMM_W)) u_tgt (
    .pc_plus4(pc_plus4), .imm(imm), .jidx(jidx), .rs_val(rs_val),
    .branch_target(branch_target), .jump_target(jump_target), .misaligned(misaligned)
  );
  assign in_trap  = state == TRAPPED;
  assign pc_plus4 = pc + XLEN'(4);
  assign addr_err = npc_sel == NPC_JR && misaligned;
  assign trap     = trap_req | addr_err;
  assign eret     = npc_sel == NPC_ERET && in_trap;
  assign cand     = (npc_sel == NPC_BRANCH && branch_taken) ? branch_target :
                    npc_sel == NPC_JUMP ? jump_target :
                    npc_sel == NPC_JR   ? rs_val :
                    eret ? epc : pc_plus4;
  // shows the would-be target even while stalled, so the fetch side can prefetch
  assign next_pc  = trap ? TRAP_VECTOR : cand;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      epc   <= '0;
      state <= NORMAL;
    end else if (trap) begin
      pc <= TRAP_VECTOR;
      if (state == NORMAL) begin
        epc   <= pc;
        state <= TRAPPED;
      end
    end else if (!stall) begin
      pc <= cand;
      if (eret) state <= NORMAL;
    end
  end
endmodule
